guess_seq_capture: RTL and testbench
====================================

Name: guess_seq_capture

Overview:
- Captures a player's digit-guess sequence for the number-guessing game from four push-buttons plus an enter key.
- Each detected press of button k writes a 1 into vector a_k at the current sequence position, then advances the position.
- Capture closes on a valid enter or when the sequence is full; the vectors are then frozen for the comparison logic downstream.
- The game top level instantiates two copies: one for player A's secret and one for player B's guess.

Parameters:
- SEQ_LEN, 7, maximum number of presses recorded; also the width of each position vector.
- MIN_LEN, 4, minimum number of recorded presses before enter is accepted.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i1  input  1  button 1 level (active high).
- i2  input  1  button 2 level.
- i3  input  1  button 3 level.
- i4  input  1  button 4 level.
- enter  input  1  enter key level (active high).
- a1  output  SEQ_LEN  positions at which button 1 was pressed; bit p = press number p (bit 0 = first press).
- a2  output  SEQ_LEN  same for button 2.
- a3  output  SEQ_LEN  same for button 3.
- a4  output  SEQ_LEN  same for button 4.
- count  output  4  number of presses recorded so far (0..SEQ_LEN).
- done  output  1  capture closed; outputs frozen.

Behaviour:
- Reset (rst_n=0, asynchronous): a1..a4=0, count=0, done=0, all edge-detect history registers=0. Outputs reflect reset immediately.
- Edge detection:
  - Each input has a one-cycle history register.
  - A press is a rising edge: sampled level 1 while the history is 0.
  - Holding a button high records exactly one press.
- Recording (done=0), on a detected press:
  - Set a_k[count] = 1.
  - Increment count.
  - Both updates take effect on the same clock edge that samples the rising level (1-cycle latency from the first sampling edge).
- Simultaneous presses in one cycle: only one is recorded. Priority is i1 > i2 > i3 > i4; the lower-priority edges are discarded, not deferred.
- Enter:
  - A rising edge on enter sets done when the post-update count is >= MIN_LEN.
  - The post-update count includes any button press recorded in the same cycle.
  - Otherwise the enter edge is ignored and capture continues.
- Full: when count reaches SEQ_LEN, done is set on the same edge, with no enter needed.
- While done=1:
  - All button and enter edges are ignored.
  - a1..a4 and count hold until reset.
  - Re-arming is by reset only.
- Invariants:
  - Each bit position is set in at most one of a1..a4.
  - Bits at positions >= count are 0 in all vectors.
  - The OR of a1..a4 equals exactly the low count bits set.
- Reset mid-capture: all state returns to the reset values immediately; the next press records at position 0.
- History registers update every cycle, including while done=1.

Optional Feature:
- Macro: INPUT_SYNC_EN.
- When defined: each of i1..i4 and enter passes through a two-flop synchronizer (reset to 0) before edge detection. This adds 2 cycles of latency to every response; all ordering and priority rules are unchanged.
- When undefined: inputs feed the edge detectors directly, and latency is as stated above.

Test Plan:
- Reset then idle 5 cycles -> a1..a4=0, count=0, done=0.
- Press i1, i3, i4 (separately, each high 2 cycles), then enter -> a1=0000001, a3=0000010, a4=0000100, a2=0, count=3. done stays 0 because 3 < MIN_LEN.
- Continue the previous case: press i2, then enter -> a2=0001000, count=4, done=1. A further i1 press leaves a1=0000001 and count=4.
- Seven presses i1,i2,i3,i4,i1,i2,i3, no enter -> a1=0010001, a2=0100010, a3=1000100, a4=0001000, count=7, done=1 on the 7th press.
- i2 and i3 rising together, then i4 held high 10 cycles -> a2 bit0=1, a3=0, a4 bit1=1, count=2. Only one press is counted for the held i4.
- Assert rst_n=0 mid-capture at count=3 -> immediate all-zero outputs. The next i4 press gives a4=0000001 and count=1.

Source files
------------

// File: rtl/guess_seq_capture.sv
// Button-sequence capture for the guessing game: one-hot position vectors per button.
// Optional INPUT_SYNC_EN adds a two-flop synchronizer on every input before edge detection.
module guess_seq_capture #(
    parameter int SEQ_LEN = 7,
    parameter int MIN_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i1,
    input  logic               i2,
    input  logic               i3,
    input  logic               i4,
    input  logic               enter,
    output logic [SEQ_LEN-1:0] a1,
    output logic [SEQ_LEN-1:0] a2,
    output logic [SEQ_LEN-1:0] a3,
    output logic [SEQ_LEN-1:0] a4,
    output logic [3:0]         count,
    output logic               done
);

    localparam logic [3:0] MIN_C  = 4'(MIN_LEN);
    localparam logic [3:0] FULL_C = 4'(SEQ_LEN);

    typedef enum logic {CAPTURE, CLOSED} state_t;
    state_t state;

    // Bit order: {enter, i4, i3, i2, i1}
    logic [4:0] lvl;
    logic [4:0] hist;
    logic [4:0] rise;

`ifdef INPUT_SYNC_EN
    logic [4:0] sync1;
    logic [4:0] sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {enter, i4, i3, i2, i1};
            sync2 <= sync1;
        end
    end

    assign lvl = sync2;
`else
    assign lvl = {enter, i4, i3, i2, i1};
`endif

    assign rise = lvl & ~hist;

    logic               press_valid;
    logic [1:0]         press_btn;
    logic [3:0]         next_count;
    logic               close;
    logic [SEQ_LEN-1:0] pos;

    always_comb begin
        press_valid = 1'b1;
        press_btn   = 2'd0;
        if (rise[0])      press_btn = 2'd0;
        else if (rise[1]) press_btn = 2'd1;
        else if (rise[2]) press_btn = 2'd2;
        else if (rise[3]) press_btn = 2'd3;
        else              press_valid = 1'b0;

        next_count = count + {3'b000, press_valid};
        close      = (rise[4] && (next_count >= MIN_C)) || (next_count == FULL_C);
        pos        = SEQ_LEN'(1) << count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CAPTURE;
            hist  <= '0;
            a1    <= '0;
            a2    <= '0;
            a3    <= '0;
            a4    <= '0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            hist <= lvl;
            case (state)
                CAPTURE: begin
                    if (press_valid) begin
                        case (press_btn)
                            2'd0:    a1 <= a1 | pos;
                            2'd1:    a2 <= a2 | pos;
                            2'd2:    a3 <= a3 | pos;
                            default: a4 <= a4 | pos;
                        endcase
                        count <= next_count;
                    end
                    if (close) begin
                        state <= CLOSED;
                        done  <= 1'b1;
                    end
                end
                CLOSED: begin
                    state <= CLOSED;
                end
                default: begin
                    state <= CAPTURE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_seq_capture.sv
// Directed, table-driven bench for guess_seq_capture (default build, no input synchronizer).
module tb_guess_seq_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i1, i2, i3, i4, enter;
    logic [6:0] a1, a2, a3, a4;
    logic [3:0] count;
    logic       done;

    int checks = 0;
    int errors = 0;

    guess_seq_capture #(.SEQ_LEN(7), .MIN_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4), .enter(enter),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .count(count), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, e, b1, b2, b3, b4;
        logic [6:0] x1, x2, x3, x4;
        logic [3:0] c;
        logic       d;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic r, e, b1, b2, b3, b4,
                     input logic [6:0] x1, x2, x3, x4,
                     input logic [3:0] c, input logic d);
        vec_t t;
        t.r = r; t.e = e; t.b1 = b1; t.b2 = b2; t.b3 = b3; t.b4 = b4;
        t.x1 = x1; t.x2 = x2; t.x3 = x3; t.x4 = x4; t.c = c; t.d = d;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [6:0] x1, x2, x3, x4,
                         input logic [3:0] c, input logic d);
        checks++;
        if ({a1, a2, a3, a4, count, done} !== {x1, x2, x3, x4, c, d}) begin
            errors++;
            $display("FAIL %s: got a1=%b a2=%b a3=%b a4=%b count=%0d done=%b, want a1=%b a2=%b a3=%b a4=%b count=%0d done=%b",
                     name, a1, a2, a3, a4, count, done, x1, x2, x3, x4, c, d);
        end
    endtask

    task automatic drive(input logic r, e, b1, b2, b3, b4);
        rst_n = r; enter = e; i1 = b1; i2 = b2; i3 = b3; i4 = b4;
    endtask

    initial begin
        // Idle after reset
        for (int k = 0; k < 5; k++) v(1,0,0,0,0,0, 7'b0,7'b0,7'b0,7'b0, 4'd0,0);
        // i1, i3, i4 each held 2 cycles, then enter with only 3 presses
        v(1,0,1,0,0,0, 7'b0000001,7'b0,7'b0,7'b0, 4'd1,0);
        v(1,0,1,0,0,0, 7'b0000001,7'b0,7'b0,7'b0, 4'd1,0);
        v(1,0,0,0,0,0, 7'b0000001,7'b0,7'b0,7'b0, 4'd1,0);
        v(1,0,0,0,1,0, 7'b0000001,7'b0,7'b0000010,7'b0, 4'd2,0);
        v(1,0,0,0,1,0, 7'b0000001,7'b0,7'b0000010,7'b0, 4'd2,0);
        v(1,0,0,0,0,0, 7'b0000001,7'b0,7'b0000010,7'b0, 4'd2,0);
        v(1,0,0,0,0,1, 7'b0000001,7'b0,7'b0000010,7'b0000100, 4'd3,0);
        v(1,0,0,0,0,1, 7'b0000001,7'b0,7'b0000010,7'b0000100, 4'd3,0);
        v(1,0,0,0,0,0, 7'b0000001,7'b0,7'b0000010,7'b0000100, 4'd3,0);
        v(1,1,0,0,0,0, 7'b0000001,7'b0,7'b0000010,7'b0000100, 4'd3,0);
        v(1,0,0,0,0,0, 7'b0000001,7'b0,7'b0000010,7'b0000100, 4'd3,0);
        // i2 then enter closes at count 4; later i1 ignored
        v(1,0,0,1,0,0, 7'b0000001,7'b0001000,7'b0000010,7'b0000100, 4'd4,0);
        v(1,0,0,0,0,0, 7'b0000001,7'b0001000,7'b0000010,7'b0000100, 4'd4,0);
        v(1,1,0,0,0,0, 7'b0000001,7'b0001000,7'b0000010,7'b0000100, 4'd4,1);
        v(1,0,0,0,0,0, 7'b0000001,7'b0001000,7'b0000010,7'b0000100, 4'd4,1);
        v(1,0,1,0,0,0, 7'b0000001,7'b0001000,7'b0000010,7'b0000100, 4'd4,1);
        v(1,0,0,0,0,0, 7'b0000001,7'b0001000,7'b0000010,7'b0000100, 4'd4,1);
        v(0,0,0,0,0,0, 7'b0,7'b0,7'b0,7'b0, 4'd0,0);
        // Seven presses fill the sequence without enter
        v(1,0,1,0,0,0, 7'b0000001,7'b0,7'b0,7'b0, 4'd1,0);
        v(1,0,0,0,0,0, 7'b0000001,7'b0,7'b0,7'b0, 4'd1,0);
        v(1,0,0,1,0,0, 7'b0000001,7'b0000010,7'b0,7'b0, 4'd2,0);
        v(1,0,0,0,0,0, 7'b0000001,7'b0000010,7'b0,7'b0, 4'd2,0);
        v(1,0,0,0,1,0, 7'b0000001,7'b0000010,7'b0000100,7'b0, 4'd3,0);
        v(1,0,0,0,0,0, 7'b0000001,7'b0000010,7'b0000100,7'b0, 4'd3,0);
        v(1,0,0,0,0,1, 7'b0000001,7'b0000010,7'b0000100,7'b0001000, 4'd4,0);
        v(1,0,0,0,0,0, 7'b0000001,7'b0000010,7'b0000100,7'b0001000, 4'd4,0);
        v(1,0,1,0,0,0, 7'b0010001,7'b0000010,7'b0000100,7'b0001000, 4'd5,0);
        v(1,0,0,0,0,0, 7'b0010001,7'b0000010,7'b0000100,7'b0001000, 4'd5,0);
        v(1,0,0,1,0,0, 7'b0010001,7'b0100010,7'b0000100,7'b0001000, 4'd6,0);
        v(1,0,0,0,0,0, 7'b0010001,7'b0100010,7'b0000100,7'b0001000, 4'd6,0);
        v(1,0,0,0,1,0, 7'b0010001,7'b0100010,7'b1000100,7'b0001000, 4'd7,1);
        v(1,0,0,0,0,0, 7'b0010001,7'b0100010,7'b1000100,7'b0001000, 4'd7,1);
        v(1,1,0,0,0,1, 7'b0010001,7'b0100010,7'b1000100,7'b0001000, 4'd7,1);
        v(0,0,0,0,0,0, 7'b0,7'b0,7'b0,7'b0, 4'd0,0);
        // i2+i3 together, then i4 held 10 cycles
        v(1,0,0,1,1,0, 7'b0,7'b0000001,7'b0,7'b0, 4'd1,0);
        for (int k = 0; k < 10; k++) v(1,0,0,0,0,1, 7'b0,7'b0000001,7'b0,7'b0000010, 4'd2,0);
        v(1,0,0,0,0,0, 7'b0,7'b0000001,7'b0,7'b0000010, 4'd2,0);
        // Press and enter in the same cycle reaching MIN_LEN closes capture
        v(1,0,1,0,0,0, 7'b0000100,7'b0000001,7'b0,7'b0000010, 4'd3,0);
        v(1,0,0,0,0,0, 7'b0000100,7'b0000001,7'b0,7'b0000010, 4'd3,0);
        v(1,1,0,0,1,0, 7'b0000100,7'b0000001,7'b0001000,7'b0000010, 4'd4,1);
        v(1,0,0,0,0,0, 7'b0000100,7'b0000001,7'b0001000,7'b0000010, 4'd4,1);
        v(0,0,0,0,0,0, 7'b0,7'b0,7'b0,7'b0, 4'd0,0);
        // Held i1 (no edge) while i4 rises: i4 recorded
        v(1,0,1,0,0,0, 7'b0000001,7'b0,7'b0,7'b0, 4'd1,0);
        v(1,0,1,0,0,1, 7'b0000001,7'b0,7'b0,7'b0000010, 4'd2,0);

        // Initial asynchronous reset, visible before any clock edge
        drive(0,0,0,0,0,0);
        #1;
        check("reset_async", 7'b0,7'b0,7'b0,7'b0, 4'd0,0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[n]) begin
            @(negedge clk);
            drive(tbl[n].r, tbl[n].e, tbl[n].b1, tbl[n].b2, tbl[n].b3, tbl[n].b4);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", n), tbl[n].x1, tbl[n].x2, tbl[n].x3, tbl[n].x4, tbl[n].c, tbl[n].d);
        end

        // Mid-capture reset at count=3, asserted between clock edges
        @(negedge clk); drive(0,0,0,0,0,0);
        @(negedge clk); drive(1,0,0,0,0,0);
        @(negedge clk); drive(1,0,0,1,0,0);
        @(negedge clk); drive(1,0,0,0,0,0);
        @(negedge clk); drive(1,0,0,0,1,0);
        @(negedge clk); drive(1,0,0,0,0,0);
        @(negedge clk); drive(1,0,1,0,0,0);
        @(negedge clk); drive(1,0,0,0,0,0);
        #1;
        check("pre_reset_count3", 7'b0000100,7'b0000001,7'b0000010,7'b0, 4'd3,0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_immediate", 7'b0,7'b0,7'b0,7'b0, 4'd0,0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); i4 = 1'b1;
        @(posedge clk); #1;
        check("post_reset_i4", 7'b0,7'b0,7'b0,7'b0000001, 4'd1,0);
        @(negedge clk); i4 = 1'b0;
        @(posedge clk); #1;
        check("post_reset_hold", 7'b0,7'b0,7'b0,7'b0000001, 4'd1,0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
